song_reader: RTL and testbench

- Consumer end of the MCU control interface; sits between the MCU and the note player.
- Takes play, reset_player and song from the MCU. Walks the selected song's notes in a registered song ROM.
- Hands each note to the note player with a new_note/note_done handshake.
- Returns a one-cycle song_done pulse to the MCU when the song ends.

---
 rtl/song_reader.sv | 117 +++++++++++
 tb/tb_song_reader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks the selected song's notes in a registered song ROM and
// hands each note to the note player with a new_note/note_done handshake.
// A duration of zero marks the end of a song; a song may also end after its
// last index slot without a marker.
module song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      reset_player,
  input  logic [SONG_W-1:0]         song,
  output logic                      song_done,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic                      new_note,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  input  logic                      note_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    WAIT_NOTE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   index;
  logic [IDX_W-1:0]   index_nxt;
  logic               take_note;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;

  // The index stops at the last slot instead of wrapping back to slot 0.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_MAX) ? i : i + 1'b1;
  endfunction

  assign rom_addr = {song, index};
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // Next-state and index update; rom_data is only meaningful in CHECK.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    take_note = 1'b0;
    case (state)
      IDLE: begin
        if (play) state_nxt = FETCH;
      end
      FETCH: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (!play) begin
          state_nxt = IDLE;
        end else if (rom_dur == '0) begin
          state_nxt = DONE;
        end else begin
          take_note = 1'b1;
          state_nxt = WAIT_NOTE;
        end
      end
      WAIT_NOTE: begin
        // note_done is honoured even while paused; pausing only decides
        // whether the next fetch starts right away.
        if (note_done) begin
          if (index == IDX_MAX) begin
            state_nxt = DONE;
          end else begin
            index_nxt = sat_inc(index);
            state_nxt = play ? FETCH : IDLE;
          end
        end
      end
      DONE: begin
        index_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, index and registered outputs; either reset source wins over all.
  always_ff @(posedge clk) begin
    if (reset || reset_player) begin
      state     <= IDLE;
      index     <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
      note      <= '0;
      duration  <= '0;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      new_note  <= take_note;
      song_done <= (state_nxt == DONE);
      if (take_note) begin
        note     <= rom_note;
        duration <= rom_dur;
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader: directed scenarios on a fixed song plus
// randomized songs checked against a note-list model built from the ROM.
module tb_song_reader;
  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play = 1'b0;
  logic reset_player = 1'b0;
  logic note_done = 1'b0;
  logic [SONG_W-1:0] song = '0;
  logic song_done;
  logic new_note;
  logic [SONG_W+IDX_W-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0] duration;

  logic [NOTE_W+DUR_W-1:0] rom [0:127];
  logic [NOTE_W+DUR_W-1:0] exp_q [$];

  int n_checks = 0;
  int n_err = 0;
  int nn_count = 0;
  int sd_count = 0;
  int bad_addr = 0;
  int max_idx3 = 0;

  always #5 clk = ~clk;

  song_reader #(.SONG_W(SONG_W), .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .play(play), .reset_player(reset_player),
    .song(song), .song_done(song_done), .rom_addr(rom_addr), .rom_data(rom_data),
    .new_note(new_note), .note(note), .duration(duration), .note_done(note_done)
  );

  // Registered song ROM: data appears one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Pulse counters and address observations.
  always @(posedge clk) begin
    if (new_note) nn_count <= nn_count + 1;
    if (song_done) sd_count <= sd_count + 1;
    if (rom_addr[6:5] !== song) bad_addr <= bad_addr + 1;
    if (song == 2'd3 && int'(rom_addr[4:0]) > max_idx3) max_idx3 <= int'(rom_addr[4:0]);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] mk(input int n, input int d);
    logic [11:0] e;
    e = {6'(n), 6'(d)};
    return e;
  endfunction

  function automatic logic [31:0] addr_of(input int s, input int i);
    logic [31:0] a;
    a = 32'(s * 32 + i);
    return a;
  endfunction

  // Step until new_note is seen; n is the number of steps taken, -1 on timeout.
  task automatic wait_new_note(input int limit, output int n);
    n = 0;
    while (!new_note && n < limit) begin
      step();
      n++;
    end
    if (!new_note) n = -1;
  endtask

  task automatic wait_song_done(input int limit, output int n);
    n = 0;
    while (!song_done && n < limit) begin
      step();
      n++;
    end
    if (!song_done) n = -1;
  endtask

  // Reference: a song is its ROM entries from slot 0 up to the first zero
  // duration, or all 32 slots when no terminator exists.
  task automatic build_song(input int s);
    logic [11:0] e;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      e = rom[7'(s * 32 + i)];
      if (e[5:0] == 6'd0) break;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_song(input int s, input bit abort_last);
    int n;
    int hold;
    bit pause;
    int sz;
    build_song(s);
    sz = exp_q.size();
    song = 2'(s);
    reset_player = 1'b1;
    step();
    reset_player = 1'b0;
    play = 1'b1;
    for (int j = 0; j < sz; j++) begin
      if (j == 0) begin
        wait_new_note(10, n);
        chk("start_latency", n, 3);
      end
      chk("song_note", note, exp_q[j][11:6]);
      chk("song_dur", duration, exp_q[j][5:0]);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) step();
      chk("note_held", note, exp_q[j][11:6]);
      if (j == sz - 1 && abort_last) begin
        reset = 1'b1;
        note_done = 1'b1;
        step();
        reset = 1'b0;
        note_done = 1'b0;
        play = 1'b0;
        chk("abort_addr", rom_addr, addr_of(s, 0));
        for (int h = 0; h < 4; h++) begin
          chk("abort_song_done", song_done, 0);
          chk("abort_new_note", new_note, 0);
          step();
        end
        return;
      end
      pause = (j < sz - 1) && ($urandom_range(0, 3) == 0);
      if (pause) begin
        play = 1'b0;
        note_done = 1'b1;
        step();
        note_done = 1'b0;
        for (int h = 0; h < 3; h++) begin
          chk("pause_no_note", new_note, 0);
          step();
        end
        chk("pause_addr", rom_addr, addr_of(s, j + 1));
        play = 1'b1;
        wait_new_note(10, n);
        chk("resume_latency", n, 3);
      end else begin
        note_done = 1'b1;
        step();
        note_done = 1'b0;
        if (j < sz - 1) begin
          wait_new_note(10, n);
          chk("next_latency", n, 2);
        end
      end
    end
    wait_song_done(10, n);
    chk("done_latency", n, (sz == 32) ? 0 : 2);
    play = 1'b0;
    step();
    chk("done_one_cycle", song_done, 0);
    chk("done_index0", rom_addr, addr_of(s, 0));
  endtask

  initial begin
    int n;
    int t;
    int sd0;
    int nn0;
    // ROM contents: song 1 fixed, songs 0 and 2 random with a terminator,
    // song 3 random with 32 nonzero durations.
    for (int i = 0; i < 128; i++) rom[i] = mk($urandom_range(0, 63), $urandom_range(1, 63));
    rom[32] = mk(10, 4);
    rom[33] = mk(12, 8);
    rom[34] = mk(0, 0);
    t = $urandom_range(2, 31);
    rom[t] = mk($urandom_range(0, 63), 0);
    t = $urandom_range(2, 31);
    rom[64 + t] = mk($urandom_range(0, 63), 0);

    // Reset state
    song = 2'd1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_new_note", new_note, 0);
    chk("rst_song_done", song_done, 0);
    chk("rst_note", note, 0);
    chk("rst_duration", duration, 0);
    chk("rst_addr", rom_addr, 32'h20);

    // Basic playback
    sd0 = sd_count;
    play = 1'b1;
    step();
    chk("t1_fetch_addr", rom_addr, 32'h20);
    chk("t1_c1_nn", new_note, 0);
    step();
    chk("t1_c2_nn", new_note, 0);
    step();
    chk("t1_c3_nn", new_note, 1);
    chk("t1_note0", note, 10);
    chk("t1_dur0", duration, 4);
    step();
    chk("t1_pulse_once", new_note, 0);
    chk("t1_note_held", note, 10);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    chk("t1_addr1", rom_addr, 32'h21);
    chk("t1_k1_nn", new_note, 0);
    step();
    chk("t1_k2_nn", new_note, 0);
    step();
    chk("t1_k3_nn", new_note, 1);
    chk("t1_note1", note, 12);
    chk("t1_dur1", duration, 8);
    step();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    step();
    chk("t1_k2_sd", song_done, 0);
    step();
    chk("t1_k3_sd", song_done, 1);
    chk("t1_k3_nn", new_note, 0);
    play = 1'b0;
    step();
    chk("t1_sd_low", song_done, 0);
    chk("t1_idx0", rom_addr, 32'h20);
    step();
    chk("t1_sd_count", sd_count - sd0, 1);

    // Song change in IDLE moves rom_addr only
    song = 2'd2;
    #1;
    chk("song_follow", rom_addr, 32'h40);
    song = 2'd1;
    #1;

    // Pause during first WAIT_NOTE
    play = 1'b1;
    step();
    step();
    step();
    chk("t2_first", note, 10);
    step();
    play = 1'b0;
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    chk("t2_addr", rom_addr, 32'h21);
    for (int h = 0; h < 4; h++) begin
      chk("t2_no_note", new_note, 0);
      step();
    end
    chk("t2_addr_kept", rom_addr, 32'h21);
    play = 1'b1;
    wait_new_note(10, n);
    chk("t2_resume_lat", n, 3);
    chk("t2_note", note, 12);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    wait_song_done(10, n);
    chk("t2_done_lat", n, 2);
    play = 1'b0;
    step();

    // Restart during second WAIT_NOTE
    play = 1'b1;
    wait_new_note(10, n);
    chk("t3_lat", n, 3);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    wait_new_note(10, n);
    chk("t3_note1", note, 12);
    step();
    reset_player = 1'b1;
    step();
    reset_player = 1'b0;
    chk("t3_note0", note, 0);
    chk("t3_dur0", duration, 0);
    chk("t3_nn", new_note, 0);
    chk("t3_addr", rom_addr, 32'h20);
    wait_new_note(10, n);
    chk("t3_restart_lat", n, 3);
    chk("t3_restart_note", note, 10);
    play = 1'b0;
    reset_player = 1'b1;
    step();
    reset_player = 1'b0;

    // Play dropped in FETCH replays the same index
    play = 1'b1;
    wait_new_note(10, n);
    chk("t5_note0", note, 10);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    play = 1'b0;
    step();
    chk("t5_check_nn", new_note, 0);
    step();
    chk("t5_idle_nn", new_note, 0);
    step();
    chk("t5_idle_nn2", new_note, 0);
    chk("t5_addr", rom_addr, 32'h21);
    play = 1'b1;
    wait_new_note(10, n);
    chk("t5_lat", n, 3);
    chk("t5_replay", note, 12);
    play = 1'b0;
    reset_player = 1'b1;
    step();
    reset_player = 1'b0;

    // Reset together with note_done on the last note
    sd0 = sd_count;
    play = 1'b1;
    wait_new_note(10, n);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    wait_new_note(10, n);
    chk("t6_last", note, 12);
    step();
    reset = 1'b1;
    note_done = 1'b1;
    step();
    reset = 1'b0;
    note_done = 1'b0;
    chk("t6_addr", rom_addr, 32'h20);
    for (int h = 0; h < 3; h++) begin
      chk("t6_sd", song_done, 0);
      chk("t6_nn", new_note, 0);
      step();
    end
    chk("t6_restart", new_note, 1);
    chk("t6_restart_note", note, 10);
    play = 1'b0;
    step();
    chk("t6_sd_count", sd_count - sd0, 0);

    // Randomized songs against the note-list model
    run_song(0, 1'b0);
    run_song(2, 1'b0);
    nn0 = nn_count;
    sd0 = sd_count;
    run_song(3, 1'b0);
    step();
    chk("t4_note_pulses", nn_count - nn0, 32);
    chk("t4_done_pulses", sd_count - sd0, 1);
    chk("t4_max_index", max_idx3, 31);
    run_song(0, 1'b0);
    run_song(2, 1'b0);
    sd0 = sd_count;
    run_song(3, 1'b1);
    chk("t6b_no_done", sd_count - sd0, 0);
    chk("addr_song_bits", bad_addr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
